// File: rtl/morse_timing_calibrator_pkg.sv
// Shared constants, calibrator state encoding and timing helpers for the Morse
// capture/decode datapath; decoder benches reuse the multipliers and defaults.
package morse_timing_calibrator_pkg;

   localparam int PULSE_CNT_W      = 16;
   localparam int DAH_MULT         = 3;
   localparam int WORD_MULT        = 7;
   localparam int TOL_SHIFT        = 2;
   localparam int DEFAULT_DIT_TIME = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_MEASURE = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_FAIL    = 3'd4
   } cal_state_t;

   // Tolerance is a quarter dit, but never zero so short dits still get slack.
   function automatic int tol_from_dit(input int dit);
      return ((dit >> TOL_SHIFT) > 0) ? (dit >> TOL_SHIFT) : 1;
   endfunction

endpackage

// File: rtl/morse_timing_calibrator_pulse_meter.sv
// Mark/space length meter: edge detect, run counters, glitch filter and timeout
// detection on ce-qualified samples of the synchronised Morse input.
module morse_pulse_meter
   import morse_timing_calibrator_pkg::*;
#(
   parameter int CNT_W     = PULSE_CNT_W,
   parameter int MIN_PULSE = 2,
   parameter int TIMEOUT   = 4095
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             signal,
   input  logic             active,
   input  logic             measuring,
   input  logic             clear,
   output logic             mark_valid,
   output logic [CNT_W-1:0] mark_len,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic             prev_sample;
   logic [CNT_W-1:0] mark_cnt;
   logic [CNT_W-1:0] space_cnt;
   logic [CNT_W-1:0] mark_next;
   logic [CNT_W-1:0] space_next;

   assign mark_next  = mark_cnt + CNT_W'(1);
   assign space_next = space_cnt + CNT_W'(1);

   // Glitch falling edges fall through to the space branch, so the space timer
   // keeps running across them; only a valid mark restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sample <= 1'b0;
         mark_cnt    <= '0;
         space_cnt   <= '0;
         mark_valid  <= 1'b0;
         mark_len    <= '0;
         timeout     <= 1'b0;
      end else begin
         mark_valid <= 1'b0;
         timeout    <= 1'b0;
         if (ce) begin
            prev_sample <= signal;
         end
         if (clear || !active) begin
            mark_cnt  <= '0;
            space_cnt <= '0;
         end else if (ce) begin
            if (signal) begin
               mark_cnt <= mark_next;
               if (mark_next == TIMEOUT_C) begin
                  timeout <= 1'b1;
               end
            end else begin
               mark_cnt <= '0;
               if (measuring && prev_sample && (mark_cnt >= MIN_C)) begin
                  mark_valid <= 1'b1;
                  mark_len   <= mark_cnt;
                  space_cnt  <= CNT_W'(1);
               end else begin
                  space_cnt <= space_next;
                  if (measuring && (space_next == TIMEOUT_C)) begin
                     timeout <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/morse_timing_calibrator.sv
// Morse timing auto-calibrator: measures marks, derives dit/dah/word/tol from the
// shortest one. Optional MORSE_CAL_AUTOSTART_EN arms on reset release and after FAIL.
module morse_timing_calibrator
   import morse_timing_calibrator_pkg::*;
#(
   parameter int CNT_W       = PULSE_CNT_W,
   parameter int CAL_MARKS   = 8,
   parameter int MIN_PULSE   = 2,
   parameter int DEFAULT_DIT = DEFAULT_DIT_TIME,
   parameter int TIMEOUT     = 4095
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             signal,
   input  logic             start,
   output logic [CNT_W-1:0] dit_time,
   output logic [CNT_W-1:0] dah_time,
   output logic [CNT_W-1:0] word_time,
   output logic [CNT_W-1:0] tol_time,
   output logic             decoder_ce,
   output logic             cal_busy,
   output logic             cal_done,
   output logic             cal_error
);

   localparam logic [CNT_W-1:0] DIT_RST  = CNT_W'(DEFAULT_DIT);
   localparam logic [CNT_W-1:0] DAH_RST  = CNT_W'(DAH_MULT * DEFAULT_DIT);
   localparam logic [CNT_W-1:0] WORD_RST = CNT_W'(WORD_MULT * DEFAULT_DIT);
   localparam logic [CNT_W-1:0] TOL_RST  = CNT_W'(tol_from_dit(DEFAULT_DIT));
   localparam logic [7:0]       MARKS_C  = 8'(CAL_MARKS);

`ifdef MORSE_CAL_AUTOSTART_EN
   localparam cal_state_t RESET_STATE = ST_ARM;
   localparam cal_state_t AFTER_FAIL  = ST_ARM;
`else
   localparam cal_state_t RESET_STATE = ST_IDLE;
   localparam cal_state_t AFTER_FAIL  = ST_IDLE;
`endif

   cal_state_t       state;
   logic [CNT_W-1:0] min_len;
   logic [CNT_W-1:0] max_len;
   logic [7:0]       mark_count;
   logic             mark_valid;
   logic [CNT_W-1:0] mark_len;
   logic             timeout;
   logic [CNT_W-1:0] min_quarter;
   logic [CNT_W-1:0] new_tol;

   assign decoder_ce  = ce & (state == ST_IDLE);
   assign cal_busy    = (state != ST_IDLE);
   assign min_quarter = min_len >> TOL_SHIFT;
   assign new_tol     = (min_quarter == '0) ? CNT_W'(1) : min_quarter;

   morse_pulse_meter #(
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .TIMEOUT   (TIMEOUT)
   ) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .signal     (signal),
      .active     ((state == ST_ARM) || (state == ST_MEASURE)),
      .measuring  (state == ST_MEASURE),
      .clear      (start),
      .mark_valid (mark_valid),
      .mark_len   (mark_len),
      .timeout    (timeout)
   );

   // start overrides every state so a restart always wins over a pending result;
   // timing registers only ever move together, in COMPUTE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_STATE;
         dit_time   <= DIT_RST;
         dah_time   <= DAH_RST;
         word_time  <= WORD_RST;
         tol_time   <= TOL_RST;
         cal_done   <= 1'b0;
         cal_error  <= 1'b0;
         min_len    <= '1;
         max_len    <= '0;
         mark_count <= '0;
      end else begin
         cal_done <= 1'b0;
         if (start) begin
            state      <= ST_ARM;
            cal_error  <= 1'b0;
            min_len    <= '1;
            max_len    <= '0;
            mark_count <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end
               ST_ARM: begin
                  if (timeout) begin
                     state <= ST_FAIL;
                  end else if (ce && !signal) begin
                     state <= ST_MEASURE;
                  end
               end
               ST_MEASURE: begin
                  if (timeout) begin
                     state <= ST_FAIL;
                  end else if (mark_valid) begin
                     if (mark_len < min_len) begin
                        min_len <= mark_len;
                     end
                     if (mark_len > max_len) begin
                        max_len <= mark_len;
                     end
                     mark_count <= mark_count + 8'd1;
                     if ((mark_count + 8'd1) == MARKS_C) begin
                        state <= ST_COMPUTE;
                     end
                  end
               end
               ST_COMPUTE: begin
                  if (max_len < {min_len[CNT_W-2:0], 1'b0}) begin
                     state <= ST_FAIL;
                  end else begin
                     dit_time  <= min_len;
                     dah_time  <= (min_len << 1) + min_len;
                     word_time <= (min_len << 3) - min_len;
                     tol_time  <= new_tol;
                     cal_done  <= 1'b1;
`ifdef MORSE_CAL_AUTOSTART_EN
                     cal_error <= 1'b0;
`endif
                     state     <= ST_IDLE;
                  end
               end
               ST_FAIL: begin
                  cal_error  <= 1'b1;
                  min_len    <= '1;
                  max_len    <= '0;
                  mark_count <= '0;
                  state      <= AFTER_FAIL;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/morse_timing_calibrator.md
Name: morse_timing_calibrator

Overview:
Auto-calibration controller for the Morse capture/decode datapath. On request, it measures CAL_MARKS mark pulses on the raw input and derives dit, dah, word and tolerance times from the shortest valid mark. It drives the decoder's dit_time/dah_time/word_time/tol_time configuration inputs. While calibrating, it gates the decoder's clock enable.

Parameters:
CNT_W, 16, pulse counter width; must equal `PULSE_CNT_W
CAL_MARKS, 8, number of valid marks measured per calibration (2..255)
MIN_PULSE, 2, marks shorter than this (ce cycles) are glitches and ignored
DEFAULT_DIT, 10, dit time loaded at reset
TIMEOUT, 4095, max mark or space length during calibration before error; 7*TIMEOUT must fit in CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable / sample strobe, shared with decoder
signal  in  1  Morse input, already synchronised
start  in  1  one-cycle request to (re)start calibration
dit_time  out  CNT_W  configured dit time
dah_time  out  CNT_W  configured dah time
word_time  out  CNT_W  configured word gap
tol_time  out  CNT_W  configured tolerance
decoder_ce  out  1  ce forwarded to decoder; low while calibrating
cal_busy  out  1  high in any state except IDLE
cal_done  out  1  one clk pulse when new timing is applied
cal_error  out  1  sticky failure flag; cleared by next start

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - dit=DEFAULT_DIT, dah=3*DEFAULT_DIT, word=7*DEFAULT_DIT, tol=max(DEFAULT_DIT>>2,1).
  - cal_busy=0, cal_done=0, cal_error=0.
  - State IDLE; previous-sample register=0; counters=0.
- decoder_ce = ce & (state==IDLE), combinational.
- Sampling: signal is sampled only on ce cycles. A mark is a run of consecutive high samples; its length is the count of those samples.
- State IDLE:
  - start -> ARM; clear cal_error, min reg to all-ones, max reg to 0, mark count to 0.
- State ARM:
  - Wait for a low sample (never measure a partial mark), then -> MEASURE.
  - Exceeding TIMEOUT high samples -> FAIL.
- State MEASURE:
  - Count mark/space length. A falling edge ends a mark.
  - Length < MIN_PULSE: discard, no count increment. The glitch also does not reset the space timer.
  - Otherwise update min/max and increment mark count.
  - Count reaching CAL_MARKS -> COMPUTE.
  - Any mark or space reaching TIMEOUT -> FAIL.
- State COMPUTE (1 clk):
  - If max < 2*min, all marks were one class (ambiguous) -> FAIL.
  - Else dit=min, dah=3*min (shift+add), word=7*min, tol=max(min>>2,1).
  - All four registers update on the same edge; cal_done pulses one cycle; -> IDLE.
- State FAIL (1 clk): set cal_error, leave timing registers unchanged, -> IDLE.
- Latency: cal_done is asserted 2 clk cycles after the ce cycle that samples the falling edge of the final mark.
- start while cal_busy: abort and restart from ARM with cleared statistics; no cal_done.
- start and a final falling edge in the same cycle: start wins.
- Reset mid-calibration: all values return to defaults immediately.
- Timing registers never change except in COMPUTE or reset, so there is no partial update visible to the decoder.
- No arithmetic overflow is possible given the TIMEOUT constraint.

Optional Feature:
MORSE_CAL_AUTOSTART_EN
- Defined: after rst_n deasserts, the FSM enters ARM as if start had pulsed. After FAIL it re-enters ARM instead of IDLE (cal_error stays set until the next start or a successful COMPUTE).
- Undefined: the FSM stays in IDLE with default timing until start.

Decomposition:
- defines.vh gains the following, reused by decoder benches:
  - DAH_MULT=3, WORD_MULT=7, TOL_SHIFT=2
  - the default-timing constants
  - FSM state encodings
- One sub-module: morse_pulse_meter (edge detect, mark/space counters, glitch filter, timeout flag). It emits mark_valid with mark_len and a timeout pulse.

Test Plan:
- Reset release, no start -> dit=10, dah=30, word=70, tol=2; cal_busy=0; decoder_ce mirrors ce.
- start, then "A","B","N" at dit=12 (8 marks) -> cal_done 2 clk after last falling edge; dit=12, dah=36, word=84, tol=3; decoder_ce low throughout calibration.
- start, then eight "E" at dit=10 -> cal_error=1, no cal_done, timings unchanged at 10/30/70/2.
- Same as scenario 2 with 1-sample glitches inserted in spaces -> identical result; glitches not counted.
- start, signal held high 4095 ce cycles -> cal_error=1, state IDLE. Then start and a valid sequence -> cal_error cleared, new timing applied.
- start, 4 marks, start again, 8 marks at dit=15 -> single cal_done with dit=15. Also assert rst_n low mid-measure -> defaults restored, cal_busy=0.
